// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - register file geometry and dump FSM state type shared with decode
package regfile_pkg;

    localparam int REG_DW = 32;
    localparam int REG_AW = 5;
    localparam int REG_N  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND0,
        ST_SEND1,
        ST_DONE
    } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - sequential register file dump over a valid/ready word stream
module regfile_dump
    import regfile_pkg::*;
#(
    parameter int DW    = REG_DW,
    parameter int AW    = REG_AW,
    parameter int NREGS = REG_N
) (
    input  logic          clk,
    input  logic          rs,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rd_addr0,
    output logic [AW-1:0] rd_addr1,
    input  logic [DW-1:0] rd_data0,
    input  logic [DW-1:0] rd_data1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_index,
    output logic          out_last
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    dump_state_t   state;
    dump_state_t   state_nxt;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_p1;
    logic [AW-1:0] idx_p2;
    logic [AW-1:0] idx_p3;
    logic [DW-1:0] buf0;
    logic [DW-1:0] buf1;
    logic          is_last;

    assign idx_p1  = idx + AW'(1);
    assign idx_p2  = idx + AW'(2);
    assign idx_p3  = idx + AW'(3);
    assign is_last = (idx_p1 == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rs) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_FETCH;
            ST_FETCH: state_nxt = ST_SEND0;
            ST_SEND0: if (out_ready) state_nxt = ST_SEND1;
            ST_SEND1: if (out_ready) state_nxt = is_last ? ST_DONE : ST_FETCH;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_index = '0;
        out_last  = 1'b0;
        case (state)
            ST_FETCH: busy = 1'b1;
            ST_SEND0: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = buf0;
                out_index = idx;
            end
            ST_SEND1: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = buf1;
                out_index = idx_p1;
                out_last  = is_last;
            end
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    // Read addresses are loaded on entry to FETCH so they are already
    // settled for the combinational read during the FETCH cycle.
    always_ff @(posedge clk) begin
        if (rs) begin
            idx      <= '0;
            buf0     <= '0;
            buf1     <= '0;
            rd_addr0 <= '0;
            rd_addr1 <= AW'(1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx      <= '0;
                        rd_addr0 <= '0;
                        rd_addr1 <= AW'(1);
                    end
                end
                ST_FETCH: begin
                    buf0 <= rd_data0;
                    buf1 <= rd_data1;
                end
                ST_SEND1: begin
                    if (out_ready && !is_last) begin
                        idx      <= idx_p2;
                        rd_addr0 <= idx_p2;
                        rd_addr1 <= idx_p3;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
